shift_seq_unit: RTL and testbench
=================================

// Module: shift_seq_unit
// PURPOSE
//  Parametrised multi-cycle shift/rotate unit for the datapath ALU. Performs SHR, SHRA, SHL, ROR, ROL
//  of an operand by a register-supplied amount, STEP bits per cycle, under a start/done handshake.
//  Sits beside the ALU; result is written to Z-low by the control sequencer once done pulses.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (power of 2, >= 8)
//  STEP   1   maximum bits shifted per cycle (power of 2, 1..WIDTH)
//  OPW    5   width of operation code
// PORTS
//  clk        in   1             clock; all state updates on rising edge
//  clr        in   1             reset, synchronous, active-high
//  start      in   1             request; accepted only when busy==0
//  op         in   OPW           operation code (see package constants)
//  a_in       in   WIDTH         operand, captured on accepting edge
//  amt        in   $clog2(WIDTH) shift amount, captured on accepting edge
//  busy       out  1             high in SHIFT state
//  done       out  1             one-cycle pulse, result valid
//  result     out  WIDTH         final value, held until next accepted start
//  carry_out  out  1             last bit shifted/rotated out (see CONFIGURATION)
//  illegal_op out  1             high with done when op was not a shift code
// BEHAVIOUR
//  - Reset (clr=1 at edge): state IDLE; busy=0, done=0, result=0, carry_out=0, illegal_op=0. clr beats start.
//  - States: IDLE -> (start) SHIFT or DONE; SHIFT -> SHIFT while remaining>0 after step, else DONE;
//    DONE -> IDLE. busy=0 in IDLE and DONE, so start in the done cycle is accepted (back-to-back).
//  - Accept: a_in, op, amt latched; remaining=amt. amt==0 or illegal op -> DONE next cycle.
//  - SHIFT: each cycle shifts working reg by n=min(STEP,remaining); remaining-=n.
//  - Latency: done high ceil(amt/STEP)+1 cycles after accepting edge (amt=0: 1 cycle).
//  - SHR zero-fill; SHRA fills with bit WIDTH-1 of a_in; SHL zero-fill; ROR/ROL circular.
//  - amt is unsigned, max WIDTH-1; no modulo handling required beyond port width.
//  - Illegal op: result=a_in unchanged, illegal_op=1 and done=1 same cycle; illegal_op clears next cycle.
//  - start while busy ignored, no effect on in-flight op. op/a_in/amt changes while busy ignored.
//  - clr mid-SHIFT: aborts; no done pulse; outputs return to reset values next cycle.
//  - done and illegal_op are single-cycle; result/carry_out hold until next accept.
// CONFIGURATION
//  SHIFT_CARRY_EN defined: carry_out = last bit leaving the operand (SHR/SHRA: bit amt-1 of a_in;
//    SHL: bit WIDTH-amt; ROR/ROL: bit wrapped last); 0 when amt==0 or illegal op.
//  Not defined: carry_out tied 0, no carry flop synthesised; all else identical.
// STRUCTURE
//  - Package shift_seq_pkg: op codes OP_SHR=5'b00101, OP_SHRA=5'b00110, OP_SHL=5'b00111,
//    OP_ROR=5'b01000, OP_ROL=5'b01001; state encoding ST_IDLE/ST_SHIFT/ST_DONE.
//  - Sub-module shift_step: combinational shift of WIDTH bits by n in 0..STEP for a given op,
//    returning shifted word and out-bit; instantiated once, driven by FSM.
// TESTING
//  1 SHRA a=0x80000012 amt=1 STEP=1 -> result 0xC0000009, done 2 cycles after accept, carry 0.
//  2 SHR a=0x80000012 amt=1 -> 0x40000009; SHL a=0x00000001 amt=31 STEP=4 -> 0x80000000, done 9 cycles.
//  3 ROL a=0x80000001 amt=4 -> 0x00000018, carry 0 (with SHIFT_CARRY_EN); ROR same -> 0x18000000.
//  4 amt=0 any op a=0x12345678 -> result 0x12345678, done 1 cycle after accept, busy never high.
//  5 op=5'b00011 -> done+illegal_op next cycle, result=a_in; start pulsed while busy -> ignored.
//  6 clr during SHIFT of amt=20 -> no done, all outputs 0 next cycle; new start accepted after.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Op codes, FSM states and decoded op kinds shared by the sequential shift unit.
// Pure declarations; no logic and no latency of its own.
package shift_seq_pkg;

  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    K_SHR  = 3'd0,
    K_SHRA = 3'd1,
    K_SHL  = 3'd2,
    K_ROR  = 3'd3,
    K_ROL  = 3'd4,
    K_ILL  = 3'd5
  } kind_t;

endpackage

// File: rtl/shift_seq_unit_step.sv
// One combinational step: shifts/rotates a word by n (0..STEP) bits, returning the word and the
// last bit pushed out; zero latency, no handshake.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  kind_t                      kind_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic [$clog2(STEP+1)-1:0]  n_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       out_bit_o
);

  localparam int AW = $clog2(WIDTH);

  logic [AW:0]   n_ext;
  logic [AW:0]   inv_ext;
  logic [AW-1:0] idx_r;
  logic [AW-1:0] idx_l;

  // Right moves lose bit n-1 last; left moves lose bit WIDTH-n last.
  assign n_ext   = (AW+1)'(n_i);
  assign inv_ext = (AW+1)'(WIDTH) - n_ext;
  assign idx_r   = n_ext[AW-1:0] - AW'(1);
  assign idx_l   = inv_ext[AW-1:0];

  always_comb begin
    dout_o    = din_i;
    out_bit_o = 1'b0;
    case (kind_i)
      K_SHR: begin
        dout_o    = din_i >> n_ext;
        out_bit_o = din_i[idx_r];
      end
      K_SHRA: begin
        dout_o    = $signed(din_i) >>> n_ext;
        out_bit_o = din_i[idx_r];
      end
      K_SHL: begin
        dout_o    = din_i << n_ext;
        out_bit_o = din_i[idx_l];
      end
      K_ROR: begin
        dout_o    = (din_i >> n_ext) | (din_i << inv_ext);
        out_bit_o = din_i[idx_r];
      end
      K_ROL: begin
        dout_o    = (din_i << n_ext) | (din_i >> inv_ext);
        out_bit_o = din_i[idx_l];
      end
      default: ;
    endcase
    if (n_i == '0) out_bit_o = 1'b0;
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle SHR/SHRA/SHL/ROR/ROL, STEP bits per cycle; done ceil(amt/STEP)+1 cycles after accept.
// start ignored while busy; carry_out tracking only when SHIFT_CARRY_EN is defined.
module shift_seq_unit
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int OPW   = 5
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic [OPW-1:0]           op,
  input  logic [WIDTH-1:0]         a_in,
  input  logic [$clog2(WIDTH)-1:0] amt,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic                     carry_out,
  output logic                     illegal_op
);

  localparam int AW = $clog2(WIDTH);
  localparam int NW = $clog2(STEP+1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AW-1:0]    rem_q, rem_d;
  kind_t            kind_q, kind_d;
  logic             ill_q, ill_d;

  kind_t            op_kind;
  logic             accept;
  logic [NW-1:0]    step_n;
  logic [WIDTH-1:0] step_dat;
  logic             step_bit;

  always_comb begin
    op_kind = K_ILL;
    case (op)
      OPW'(OP_SHR):  op_kind = K_SHR;
      OPW'(OP_SHRA): op_kind = K_SHRA;
      OPW'(OP_SHL):  op_kind = K_SHL;
      OPW'(OP_ROR):  op_kind = K_ROR;
      OPW'(OP_ROL):  op_kind = K_ROL;
      default:       op_kind = K_ILL;
    endcase
  end

  // The done cycle is not busy, so a new request can start back-to-back.
  assign accept = start && (state_q != ST_SHIFT);

  always_comb begin
    if (32'(rem_q) >= 32'(STEP)) step_n = NW'(STEP);
    else                         step_n = NW'(rem_q);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .kind_i    (kind_q),
    .din_i     (work_q),
    .n_i       (step_n),
    .dout_o    (step_dat),
    .out_bit_o (step_bit)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    kind_d  = kind_q;
    ill_d   = ill_q;
    case (state_q)
      ST_SHIFT: begin
        work_d = step_dat;
        rem_d  = rem_q - AW'(step_n);
        if (rem_d == '0) state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          work_d  = a_in;
          rem_d   = amt;
          kind_d  = op_kind;
          ill_d   = (op_kind == K_ILL);
          state_d = ((amt == '0) || (op_kind == K_ILL)) ? ST_DONE : ST_SHIFT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      kind_q  <= K_ILL;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      kind_q  <= kind_d;
      ill_q   <= ill_d;
    end
  end

  assign busy       = (state_q == ST_SHIFT);
  assign done       = (state_q == ST_DONE);
  assign illegal_op = done && ill_q;
  assign result     = work_q;

`ifdef SHIFT_CARRY_EN
  logic carry_q, carry_d;

  always_comb begin
    carry_d = carry_q;
    if (accept)                     carry_d = 1'b0;
    else if (state_q == ST_SHIFT)   carry_d = step_bit;
  end

  always_ff @(posedge clk) begin
    if (clr) carry_q <= 1'b0;
    else     carry_q <= carry_d;
  end

  assign carry_out = carry_q;
`else
  logic unused_step_bit;
  assign unused_step_bit = step_bit;
  assign carry_out       = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_unit.sv
// Randomized and directed check of shift_seq_unit (WIDTH=32, STEP=4) against a bit-level reference.
module tb_shift_seq_unit;
  import shift_seq_pkg::*;

  localparam int W    = 32;
  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        clr, start;
  logic [4:0]  op;
  logic [31:0] a_in;
  logic [4:0]  amt;
  logic        busy, done, carry_out, illegal_op;
  logic [31:0] result;

  always #5 clk = ~clk;

  shift_seq_unit #(.WIDTH(W), .STEP(STEP), .OPW(5)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .op         (op),
    .a_in       (a_in),
    .amt        (amt),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carry_out  (carry_out),
    .illegal_op (illegal_op)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // Reference: each result bit is picked directly from the source operand.
  function automatic void ref_op(input logic [4:0] o, input logic [31:0] a, input int k,
                                 output logic [31:0] r, output logic c, output logic ill);
    r = '0; c = 1'b0; ill = 1'b0;
    case (o)
      OP_SHR:  begin for (int i = 0; i < W; i++) r[i] = (i + k < W) ? a[i+k] : 1'b0;  if (k > 0) c = a[k-1]; end
      OP_SHRA: begin for (int i = 0; i < W; i++) r[i] = (i + k < W) ? a[i+k] : a[W-1]; if (k > 0) c = a[k-1]; end
      OP_SHL:  begin for (int i = 0; i < W; i++) r[i] = (i >= k) ? a[i-k] : 1'b0;      if (k > 0) c = a[W-k]; end
      OP_ROR:  begin for (int i = 0; i < W; i++) r[i] = a[(i + k) % W];               if (k > 0) c = a[k-1]; end
      OP_ROL:  begin for (int i = 0; i < W; i++) r[i] = a[(i - k + W) % W];           if (k > 0) c = a[W-k]; end
      default: begin r = a; ill = 1'b1; end
    endcase
`ifndef SHIFT_CARRY_EN
    c = 1'b0;
`endif
  endfunction

  // Model state: cycles left until done (1 = done cycle, 0 = idle).
  int          m_cnt   = 0;
  logic [31:0] m_res   = '0;
  logic        m_carry = 1'b0;
  logic        m_ill   = 1'b0;
  logic [31:0] t_r;
  logic        t_c, t_i;
  bit          can_acc;

  always @(posedge clk) begin
    if (clr) begin
      m_cnt = 0; m_res = '0; m_carry = 1'b0; m_ill = 1'b0;
    end else begin
      can_acc = (m_cnt <= 1);
      if (m_cnt > 0) m_cnt--;
      if (start && can_acc) begin
        ref_op(op, a_in, int'(amt), t_r, t_c, t_i);
        m_res = t_r; m_carry = t_c; m_ill = t_i;
        m_cnt = (amt == 0 || t_i) ? 1 : (int'(amt) + STEP - 1) / STEP + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_cnt > 1));
      chk("done", 32'(done), 32'(m_cnt == 1));
      chk("illegal_op", 32'(illegal_op), 32'(m_cnt == 1 && m_ill));
      if (m_cnt <= 1) begin
        chk("result", result, m_res);
        chk("carry_out", 32'(carry_out), 32'(m_carry));
      end
    end
  end

  task automatic run_op(input string nm, input logic [4:0] o, input logic [31:0] a, input logic [4:0] k,
                        input logic [31:0] er, input int elat, input logic ec, input logic eill, input bit poke);
    int  lat;
    bit  saw_busy;
    logic exp_c;
    lat = 0; saw_busy = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = o; a_in = a; amt = k;
    @(posedge clk); #1;
    start = 1'b0; op = 5'($urandom); a_in = $urandom; amt = 5'($urandom);
    for (int cyc = 1; cyc <= 60 && lat == 0; cyc++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
      if (done) lat = cyc;
      else if (poke && cyc == 1) start = 1'b1;
      else if (poke && cyc == 2) start = 1'b0;
    end
    start = 1'b0;
`ifdef SHIFT_CARRY_EN
    exp_c = ec;
`else
    exp_c = 1'b0;
`endif
    chk({nm, "_latency"}, 32'(lat), 32'(elat));
    chk({nm, "_result"}, result, er);
    chk({nm, "_carry"}, 32'(carry_out), 32'(exp_c));
    chk({nm, "_illegal"}, 32'(illegal_op), 32'(eill));
    chk({nm, "_busy_seen"}, 32'(saw_busy), 32'(elat > 1));
  endtask

  initial begin
    bit saw_done;
    clr = 1'b1; start = 1'b0; op = '0; a_in = '0; amt = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    @(posedge clk); #1;
    clr = 1'b0;

    run_op("shra1", OP_SHRA, 32'h80000012, 5'd1,  32'hC0000009, 2, 1'b0, 1'b0, 1'b0);
    run_op("shr1",  OP_SHR,  32'h80000012, 5'd1,  32'h40000009, 2, 1'b0, 1'b0, 1'b0);
    run_op("shl31", OP_SHL,  32'h00000001, 5'd31, 32'h80000000, 9, 1'b0, 1'b0, 1'b1);
    run_op("rol4",  OP_ROL,  32'h80000001, 5'd4,  32'h00000018, 2, 1'b0, 1'b0, 1'b0);
    run_op("ror4",  OP_ROR,  32'h80000001, 5'd4,  32'h18000000, 2, 1'b0, 1'b0, 1'b0);
    run_op("amt0",  OP_SHL,  32'h12345678, 5'd0,  32'h12345678, 1, 1'b0, 1'b0, 1'b0);
    run_op("ill",   5'b00011, 32'hDEADBEEF, 5'd7, 32'hDEADBEEF, 1, 1'b0, 1'b1, 1'b0);
    run_op("shr5",  OP_SHR,  32'h00000010, 5'd5,  32'h00000000, 3, 1'b1, 1'b0, 1'b0);
    run_op("rol8",  OP_ROL,  32'h01000000, 5'd8,  32'h00000001, 3, 1'b1, 1'b0, 1'b0);

    @(posedge clk); #1;
    start = 1'b1; op = OP_SHR; a_in = 32'hFFFF_FFFF; amt = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("clr_result", result, 32'h0);
    chk("clr_busy", 32'(busy), 32'h0);
    chk("clr_carry", 32'(carry_out), 32'h0);
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("clr_no_done", 32'(saw_done), 32'h0);
    run_op("after_clr", OP_SHRA, 32'hF0000000, 5'd8, 32'hFFF00000, 3, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      int s;
      @(posedge clk); #1;
      clr   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 2) == 0);
      s     = int'($urandom_range(0, 5));
      case (s)
        0: op = OP_SHR;
        1: op = OP_SHRA;
        2: op = OP_SHL;
        3: op = OP_ROR;
        4: op = OP_ROL;
        default: op = 5'($urandom);
      endcase
      a_in = $urandom;
      amt  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
    end
    @(posedge clk); #1;
    clr = 1'b0; start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
